// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the serial adder slice:
//   state_t   - controller state encoding (IDLE, RUN, DONE)
//   beats()   - number of CHUNK-bit beats needed for a WIDTH-bit add
//   cnt_width - beat counter width, never narrower than 1 bit
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beats(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/fa_chunk.sv
// fa_chunk
// Purely combinational ripple of CHUNK full adders.
// Ports:
//   a, b   [CHUNK-1:0] in  - operand slices
//   cin               in  - carry into bit 0
//   sum    [CHUNK-1:0] out - slice sum
//   carry             out - carry out of the top bit
//   c_msb             out - carry into the top bit (overflow detection)
module fa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             carry,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[CHUNK];
    assign c_msb = c[CHUNK - 1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Multi-cycle adder: sum = a + b + cin over WIDTH bits, CHUNK bits per clock.
// A registered carry links successive chunks; the result and the unsigned
// carry-out / signed overflow flags are held in dedicated output registers.
// Ports:
//   clk, rst_n            - rising-edge clock, async active-low reset
//   in_valid / in_ready   - operand handshake (a, b, cin sampled at accept)
//   out_valid / out_ready - result handshake
//   sum, carry, ovf       - result, carry out of bit WIDTH-1, 2's-comp overflow
//   busy                  - high while an operation is in RUN or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one CHUNK-bit beat per cycle, NBEATS beats in total
// DONE  | result presented with out_valid until out_ready
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);

    localparam int NBEATS = beats(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(NBEATS);
    localparam int TOP    = WIDTH - CHUNK;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("serial_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  s_sh;
    logic [WIDTH-1:0]  s_nxt;
    logic [WIDTH-1:0]  chunk_ext;
    logic              c_reg;
    logic [CNT_W-1:0]  cnt;
    logic              in_ready_q;
    logic [CHUNK-1:0]  ch_sum;
    logic              ch_carry;
    logic              ch_c_msb;
    logic              accept;
    logic              last_beat;

    fa_chunk #(.CHUNK(CHUNK)) u_fa (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .cin   (c_reg),
        .sum   (ch_sum),
        .carry (ch_carry),
        .c_msb (ch_c_msb)
    );

    // in_ready_q is only ever high in IDLE, so it doubles as the accept gate.
    assign accept    = in_valid && in_ready_q;
    assign last_beat = (state == RUN) && (cnt == LAST);

    // New result bits enter at the top; after NBEATS shifts the first chunk
    // has reached bit 0. Written with shifts so CHUNK == WIDTH still elaborates.
    always_comb begin
        chunk_ext              = '0;
        chunk_ext[CHUNK-1:0]   = ch_sum;
        s_nxt                  = (s_sh >> CHUNK) | (chunk_ext << TOP);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered ready keeps in_ready low while reset is asserted and
    // raises it on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        s_sh  <= '0;
                        c_reg <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    s_sh  <= s_nxt;
                    c_reg <= ch_carry;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers only move on the completing beat, so the previous
    // result stays readable through IDLE and the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (last_beat) begin
            sum   <= s_nxt;
            carry <= ch_carry;
            ovf   <= ch_c_msb ^ ch_carry;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that computes `sum = a + b + cin` over `WIDTH` bits, processing `CHUNK` bits per clock through a combinational full-adder chain. A registered carry links successive chunks. It is the sequential successor to the single-bit full adder and is used where a wide adder must trade latency for area. Operands enter and results leave through valid/ready handshakes. The block also reports unsigned carry-out and signed overflow.

## Interface
- `WIDTH`, 16, operand and result width in bits.
- `CHUNK`, 4, bits added per cycle. `WIDTH % CHUNK` must be 0. `NBEATS = WIDTH/CHUNK`.
- `clk` input 1, rising-edge clock.
- `rst_n` input 1, asynchronous active-low reset.
- `in_valid` input 1, operands present.
- `in_ready` output 1, block can accept operands.
- `a` input WIDTH, operand A, sampled only at accept.
- `b` input WIDTH, operand B, sampled only at accept.
- `cin` input 1, carry-in, sampled only at accept.
- `out_valid` output 1, result present.
- `out_ready` input 1, consumer takes the result.
- `sum` output WIDTH, result `(a+b+cin) mod 2^WIDTH`.
- `carry` output 1, carry out of bit WIDTH-1.
- `ovf` output 1, two's-complement overflow.
- `busy` output 1, high in RUN and DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: load `a` and `b` into shift registers, load the carry register with `cin`, clear the beat counter, and go to RUN.
- **RUN**
  - Each cycle, add the low CHUNK bits of both shift registers to the carry register.
  - Shift the CHUNK result bits into the top of the sum shift register, shift the operands right by CHUNK, update the carry register, and increment the counter.
  - On the beat where counter == NBEATS-1:
    - load `sum` from the completed shift register and `carry` from the final carry;
    - set `ovf` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, both taken from that beat;
    - go to DONE.
- **DONE**
  - `out_valid`=1. `sum`, `carry` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there, and operand changes after accept have no effect.
- `sum`, `carry` and `ovf` are dedicated output registers. They change only on the completing RUN beat and hold the last result through IDLE and the next RUN.
- The beat counter is `$clog2(NBEATS)` bits wide, with a minimum width of 1.
- NBEATS=1 (CHUNK=WIDTH) is legal: RUN lasts exactly one cycle.

## Timing
- All outputs are zero on reset: `in_ready`=0 while `rst_n` is low, and `in_ready`=1 from the first cycle after release.
- Reset during RUN or DONE aborts the operation immediately. The result is discarded and there is no `out_valid` pulse.
- Latency: if accept occurs on edge k, `out_valid` rises after edge k+NBEATS.
- DONE lasts at least one cycle. `out_ready` held high gives DONE→IDLE on the next edge.
- Throughput is one operation per NBEATS+2 cycles with no backpressure. There is no overlap between result hold and a new accept.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Simultaneous `out_valid && out_ready`: the result is consumed on that edge, and `in_ready`=1 on the following cycle.

## Structure
- The shared package `adder_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`, 2 bits;
  - a `beats(WIDTH, CHUNK)` constant function.
- The sub-module `fa_chunk` (parameter `CHUNK`) is a purely combinational ripple of full adders. It has inputs `a`, `b` and `cin`, and outputs `sum`, `carry` and `c_msb` (the carry into its top bit, used for `ovf`).
- The top level `serial_adder` contains the FSM, the shift registers, the counter, the output registers and an elaboration-time check on `WIDTH % CHUNK`.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- a=0x1234, b=0x4321, cin=0 → sum=0x5555, carry=0, ovf=0. `out_valid` rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, carry=1, ovf=0. The carry propagates through all 4 beats.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, carry=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, carry=1, ovf=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `sum`, `carry` and `ovf` stay stable, `in_ready`=0, and a new `in_valid` with a=0x0001 is ignored. Release → IDLE on the next cycle, and `sum` still reads the old result.
- Reset pulse after 2 RUN beats → all outputs 0 and no `out_valid`. After release, `in_ready`=1 and a=0x0002, b=0x0003 gives sum=0x0005.
- 1000 random `{a, b, cin}` with random `out_ready` stalls, checked against a `{carry, sum} = a+b+cin` model. Repeat with CHUNK=1 (latency 16) and CHUNK=16 (latency 1).
